// File: rtl/hft_pkg.sv
// Shared constants and state encoding for the arbitrage-cycle extraction path.
// Field slices of a vertmat word: {pred[31:25], dist[24:0]}.
package hft_pkg;

   localparam logic [6:0]  NO_PRED  = 7'h7F;
   localparam logic [24:0] INF_DIST = 25'h0FFFFFF;

   localparam int PRED_MSB = 31;
   localparam int PRED_LSB = 25;
   localparam int DIST_MSB = 24;
   localparam int DIST_LSB = 0;

   typedef enum logic [2:0] {
      CX_IDLE,
      CX_SEEK,
      CX_MARK,
      CX_EMIT,
      CX_DONE
   } cx_state_t;

endpackage

// File: rtl/cycle_extract.sv
// Walks Bellman predecessor pointers to land on a negative cycle, then streams its vertices out.
// Optional CYCLE_WEIGHT_EN adds adjmat input and a signed running cycle_weight output.
module cycle_extract
   import hft_pkg::*;
#(
   parameter int NODES  = 4,
   parameter int IDX_W  = 7,
   parameter int DIST_W = 25
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [7:0]               src,
   input  logic [31:0]              vertmat [NODES:0],
`ifdef CYCLE_WEIGHT_EN
   input  logic [31:0]              adjmat [NODES:0][NODES:0],
   output logic signed [31:0]       cycle_weight,
`endif
   output logic                     busy,
   output logic [IDX_W-1:0]         path_vertex,
   output logic                     path_valid,
   input  logic                     path_ready,
   output logic                     path_last,
   output logic                     done,
   output logic                     found,
   output logic [IDX_W-1:0]         cycle_len
);

   cx_state_t         state_q;
   logic [IDX_W-1:0]  cur_q;
   logic [IDX_W-1:0]  anchor_q;
   logic [IDX_W-1:0]  len_q;
   logic [IDX_W-1:0]  len_d;
   logic [7:0]        step_q;
   logic              busy_q;
   logic              valid_q;
   logic              done_q;
   logic              found_q;

   logic [31:0]       vm_cur;
   logic [IDX_W-1:0]  pred_c;
   logic [DIST_W-1:0] dist_c;
   logic              last_c;

   function automatic logic link_bad(input logic [IDX_W-1:0] p, input logic [DIST_W-1:0] d);
      return (p == NO_PRED) || (int'(p) >= NODES) || (d == INF_DIST);
   endfunction

   always_comb begin
      vm_cur = '0;
      for (int i = 0; i <= NODES; i++) begin
         if (cur_q == IDX_W'(i)) vm_cur = vertmat[i];
      end
   end

   assign pred_c = vm_cur[PRED_MSB:PRED_LSB];
   assign dist_c = vm_cur[DIST_MSB:DIST_LSB];
   assign last_c = (state_q == CX_EMIT) && (pred_c == anchor_q);
   assign len_d  = len_q + 1'b1;

`ifdef CYCLE_WEIGHT_EN
   logic signed [31:0] weight_q;
   logic signed [31:0] weight_d;
   logic        [31:0] edge_w;

   // Weight of the edge pred(cur) -> cur taken by the current beat.
   always_comb begin
      edge_w = '0;
      for (int i = 0; i <= NODES; i++) begin
         for (int j = 0; j <= NODES; j++) begin
            if (pred_c == IDX_W'(i) && cur_q == IDX_W'(j)) edge_w = adjmat[i][j];
         end
      end
   end

   assign weight_d     = weight_q + signed'(edge_w);
   assign cycle_weight = weight_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         weight_q <= '0;
      end else if (start && (state_q == CX_IDLE || state_q == CX_DONE)) begin
         weight_q <= '0;
      end else if (state_q == CX_EMIT && path_ready) begin
         weight_q <= weight_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= CX_IDLE;
         cur_q    <= '0;
         anchor_q <= '0;
         len_q    <= '0;
         step_q   <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
      end else begin
         case (state_q)
            CX_IDLE, CX_DONE: begin
               if (start) begin
                  state_q <= CX_SEEK;
                  step_q  <= '0;
                  len_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  found_q <= 1'b0;
               end
            end
            // Step 0 loads src; steps 1..NODES follow predecessors.
            CX_SEEK: begin
               if (step_q == 8'd0) begin
                  if (int'(src) >= NODES) begin
                     state_q <= CX_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cur_q  <= src[IDX_W-1:0];
                     step_q <= 8'd1;
                  end
               end else if (link_bad(pred_c, dist_c)) begin
                  state_q <= CX_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cur_q <= pred_c;
                  if (int'(step_q) == NODES) state_q <= CX_MARK;
                  else step_q <= step_q + 8'd1;
               end
            end
            CX_MARK: begin
               anchor_q <= cur_q;
               valid_q  <= 1'b1;
               state_q  <= CX_EMIT;
            end
            CX_EMIT: begin
               if (path_ready) begin
                  len_q <= len_d;
                  cur_q <= pred_c;
                  if (last_c) begin
                     state_q <= CX_DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     found_q <= 1'b1;
                  end else if (link_bad(pred_c, dist_c) || int'(len_d) >= NODES) begin
                     state_q <= CX_DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= CX_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign path_vertex = cur_q;
   assign path_valid  = valid_q;
   assign path_last   = last_c;
   assign done        = done_q;
   assign found       = found_q;
   assign cycle_len   = len_q;

endmodule
